// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: fetches the block holding miss_pc from IRAM
// one word per beat, packs it into cache block format and strobes the write.
module icache_refill_ctrl #(
  parameter int PC_SIZE     = 32,
  parameter int BLOCK_SIZE  = 128,
  parameter int OFFSET_BITS = $clog2(BLOCK_SIZE / 8)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 miss_req,
  input  logic [PC_SIZE-1:0]   miss_pc,
  input  logic                 flush,
  output logic                 busy,
  output logic                 mem_req,
  output logic [PC_SIZE-1:0]   mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic                 cache_we,
  output logic [0:BLOCK_SIZE-1] cache_block
);

  // state | meaning
  // IDLE  | no refill; waiting for a miss
  // REQ   | read request for current beat held until granted
  // WAIT  | granted; waiting for the read word
  // DRAIN | flushed with a beat outstanding; swallow its response
  // WRITE | block complete; one-cycle cache write strobe

  localparam int BEATS = BLOCK_SIZE / 32;
  localparam int BW    = $clog2(BEATS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [PC_SIZE-1:0] BLK_MASK =
    {{(PC_SIZE - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [BW-1:0]       beat;
  logic [PC_SIZE-1:0]  base;
  logic                last_beat;

  assign last_beat = (beat == BW'(BEATS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (miss_req && !flush) state_nxt = S_REQ;
      S_REQ: begin
        if (flush)        state_nxt = mem_gnt ? S_DRAIN : S_IDLE;
        else if (mem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (flush)           state_nxt = mem_rvalid ? S_IDLE : S_DRAIN;
        else if (mem_rvalid) state_nxt = last_beat ? S_WRITE : S_REQ;
      end
      S_DRAIN: if (mem_rvalid) state_nxt = S_IDLE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= S_IDLE;
      beat        <= '0;
      base        <= '0;
      cache_block <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (miss_req && !flush) begin
            base <= miss_pc & BLK_MASK;
            beat <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid && !flush) begin
            // Ascending vector: byte k lands MSB-first at index 32*beat+8*k.
            for (int i = 0; i < BEATS; i++) begin
              if (beat == BW'(i)) begin
                for (int k = 0; k < 4; k++) begin
                  cache_block[32*i + 8*k +: 8] <= mem_rdata[8*k +: 8];
                end
              end
            end
            if (!last_beat) beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign mem_req  = (state == S_REQ);
  assign mem_addr = mem_req ? (base + (PC_SIZE'(beat) << 2)) : '0;
  assign cache_we = (state == S_WRITE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a per-cycle vector table for the basic
// refill plus hand-written sequences for waits, flushes and reset.
module tb_icache_refill_ctrl;

  logic          clk = 1'b0;
  logic          nrst;
  logic          miss_req;
  logic [31:0]   miss_pc;
  logic          flush;
  logic          busy;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          cache_we;
  logic [0:127]  cache_block;

  icache_refill_ctrl dut (
    .clk(clk), .nrst(nrst), .miss_req(miss_req), .miss_pc(miss_pc), .flush(flush),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .cache_we(cache_we),
    .cache_block(cache_block)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic [31:0] pc;
    logic        fl, gnt, rv;
    logic [31:0] rd;
    logic        e_busy, e_req;
    logic [31:0] e_addr;
    logic        e_we;
  } vec_t;

  vec_t        tv[10];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          gw[4];
  int          rw[4];
  logic [31:0] wd[4];
  logic [0:127] cb;

  function automatic vec_t mk(logic mr, logic [31:0] pc, logic fl, logic gnt, logic rv,
                              logic [31:0] rd, logic eb, logic er, logic [31:0] ea, logic ew);
    vec_t v;
    v.mr = mr; v.pc = pc; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_busy = eb; v.e_req = er; v.e_addr = ea; v.e_we = ew;
    return v;
  endfunction

  // Reference packing straight from the bit-level mapping.
  function automatic logic [0:127] pack(input logic [31:0] w[4]);
    logic [0:127] r;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 8; j++)
          r[32*i + 8*k + j] = w[i][8*k + 7 - j];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    miss_req = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Assumes REQ is visible; completes one zero-wait beat.
  task automatic beat_zw(input logic [31:0] w);
    mem_gnt = 1; step(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = w; step(); mem_rvalid = 0;
  endtask

  // Refill driven by an IRAM model using gw/rw wait counts and wd data.
  // Returns with the WRITE cycle visible.
  task automatic refill(input logic [31:0] pc, input bit hold, input int exp_we, input string nm);
    logic [31:0] base_e;
    int b, wc, cyc, we_cyc;
    base_e = pc & 32'hFFFF_FFF0;
    b = 0; wc = 0; cyc = 0; we_cyc = -1;
    clr(); miss_req = 1; miss_pc = pc;
    step(); cyc = 1;
    if (!hold) miss_req = 0;
    while (we_cyc < 0 && cyc < 200) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (cache_we) we_cyc = cyc;
      else if (mem_req) begin
        chk($sformatf("%s_addr_c%0d", nm, cyc), mem_addr, base_e + 32'(4 * b));
        if (wc == gw[b & 3]) begin mem_gnt = 1; wc = 0; end
        else wc++;
      end else if (busy) begin
        if (wc == rw[b & 3]) begin
          mem_rvalid = 1; mem_rdata = wd[b & 3]; b++; wc = 0;
        end else wc++;
      end
      if (we_cyc < 0) begin step(); cyc++; end
    end
    mem_gnt = 0; mem_rvalid = 0;
    chk({nm, "_we_cycle"}, 128'(we_cyc), 128'(exp_we));
    chk({nm, "_block"}, cache_block, pack(wd));
  endtask

  initial begin
    tv[0] = mk(1, 32'h1234, 0, 0, 0, 32'h0,        1, 1, 32'h1230, 0);
    tv[1] = mk(0, 32'h1234, 0, 1, 0, 32'h0,        1, 0, 32'h0,    0);
    tv[2] = mk(0, 32'h1234, 0, 0, 1, 32'h12345678, 1, 1, 32'h1234, 0);
    tv[3] = mk(0, 32'h1234, 0, 1, 0, 32'h0,        1, 0, 32'h0,    0);
    tv[4] = mk(0, 32'h1234, 0, 0, 1, 32'h00000013, 1, 1, 32'h1238, 0);
    tv[5] = mk(0, 32'h1234, 0, 1, 0, 32'h0,        1, 0, 32'h0,    0);
    tv[6] = mk(0, 32'h1234, 0, 0, 1, 32'hDEADBEEF, 1, 1, 32'h123C, 0);
    tv[7] = mk(0, 32'h1234, 0, 1, 0, 32'h0,        1, 0, 32'h0,    0);
    tv[8] = mk(0, 32'h1234, 0, 0, 1, 32'h0000006F, 1, 0, 32'h0,    1);
    tv[9] = mk(0, 32'h1234, 0, 0, 0, 32'h0,        0, 0, 32'h0,    0);

    nrst = 0; clr(); miss_pc = '0;
    step(); step();
    chk("reset_outs", {busy, mem_req, mem_addr, cache_we}, '0);
    chk("reset_block", cache_block, '0);
    nrst = 1;

    // Scenario 1: zero-wait refill, vector table
    for (int r = 0; r < 10; r++) begin
      miss_req = tv[r].mr; miss_pc = tv[r].pc; flush = tv[r].fl;
      mem_gnt = tv[r].gnt; mem_rvalid = tv[r].rv; mem_rdata = tv[r].rd;
      step();
      chk($sformatf("s1_vec%0d", r), {busy, mem_req, mem_addr, cache_we},
          {tv[r].e_busy, tv[r].e_req, tv[r].e_addr, tv[r].e_we});
    end
    clr();
    wd = '{32'h12345678, 32'h00000013, 32'hDEADBEEF, 32'h0000006F};
    cb = cache_block;
    chk("s1_block", cb, pack(wd));
    chk("s1_byte0", cb[0:7], 8'h78);
    chk("s1_byte1", cb[8:15], 8'h56);
    chk("s1_byte2", cb[16:23], 8'h34);
    chk("s1_byte3", cb[24:31], 8'h12);
    chk("s1_byte4", cb[32:39], 8'h13);
    chk("s1_byte12", cb[96:103], 8'h6F);

    // Scenario 2: grant and response waits
    gw = '{0, 3, 0, 0}; rw = '{0, 0, 2, 0};
    refill(32'h1234, 0, 14, "s2");
    step();
    chk("s2_after_we", {busy, cache_we}, 2'b00);
    gw = '{0, 0, 0, 0}; rw = '{0, 0, 0, 0};

    // Scenario 3: flush in WAIT of beat 2, response 2 cycles later
    clr(); miss_req = 1; miss_pc = 32'h3000; step(); miss_req = 0;
    beat_zw(32'h1111_1111); beat_zw(32'h2222_2222);
    chk("s3_req_b2", {mem_req, mem_addr}, {1'b1, 32'h3008});
    mem_gnt = 1; step(); mem_gnt = 0;
    flush = 1; step(); flush = 0;
    chk("s3_drain1", {busy, mem_req, cache_we}, 3'b100);
    step();
    chk("s3_drain2", {busy, mem_req, cache_we}, 3'b100);
    mem_rvalid = 1; mem_rdata = 32'h3333_3333; step(); mem_rvalid = 0;
    chk("s3_idle", {busy, mem_req, cache_we}, 3'b000);
    step();
    chk("s3_idle2", {busy, mem_req, cache_we}, 3'b000);

    // flush with rvalid in the same WAIT cycle goes straight to IDLE
    miss_req = 1; miss_pc = 32'h3100; step(); miss_req = 0;
    mem_gnt = 1; step(); mem_gnt = 0;
    flush = 1; mem_rvalid = 1; step(); flush = 0; mem_rvalid = 0;
    chk("s3_flush_rv", {busy, mem_req, cache_we}, 3'b000);

    // flush with grant in REQ drains the outstanding beat
    miss_req = 1; miss_pc = 32'h3200; step(); miss_req = 0;
    flush = 1; mem_gnt = 1; step(); flush = 0; mem_gnt = 0;
    chk("s3_req_gnt_flush", {busy, mem_req, cache_we}, 3'b100);
    mem_rvalid = 1; step(); mem_rvalid = 0;
    chk("s3_drain_done", {busy, mem_req, cache_we}, 3'b000);

    // Scenario 4: flush in REQ without grant, then flush during WRITE
    miss_req = 1; miss_pc = 32'h4000; step(); miss_req = 0;
    chk("s4_req", {busy, mem_req, mem_addr}, {2'b11, 32'h4000});
    flush = 1; step(); flush = 0;
    chk("s4_flush_idle", {busy, mem_req}, 2'b00);
    step();
    chk("s4_no_req", {busy, mem_req}, 2'b00);
    wd = '{32'hA5C3_0F81, 32'h0102_0304, 32'hFFEE_DDCC, 32'h8000_0001};
    refill(32'h4444, 0, 9, "s4");
    flush = 1;
    chk("s4_we_flush", cache_we, 1'b1);
    step(); flush = 0;
    chk("s4_after_we", {busy, cache_we}, 2'b00);
    chk("s4_block_held", cache_block, pack(wd));

    // Scenario 5: reset during WAIT of beat 1
    miss_req = 1; miss_pc = 32'h5000; step(); miss_req = 0;
    beat_zw(32'h5555_5555);
    mem_gnt = 1; step(); mem_gnt = 0;
    nrst = 0; step(); nrst = 1;
    chk("s5_reset_outs", {busy, mem_req, mem_addr, cache_we}, '0);
    chk("s5_reset_block", cache_block, '0);
    step();
    chk("s5_stays_idle", {busy, mem_req, cache_we}, 3'b000);
    wd = '{32'h0BAD_F00D, 32'h7654_3210, 32'h0000_00FF, 32'hCAFE_BABE};
    refill(32'h2008, 0, 9, "s5");
    step();

    // Scenario 6: miss_req held through a refill, back-to-back miss after WRITE
    wd = '{32'h1357_9BDF, 32'h2468_ACE0, 32'hF0F0_0F0F, 32'h3C3C_C3C3};
    refill(32'h1234, 1, 9, "s6a");
    miss_req = 1; miss_pc = 32'h40; step();
    chk("s6_gap_idle", {busy, mem_req, cache_we}, 3'b000);
    wd = '{32'h4444_0000, 32'h0000_4444, 32'h4040_4040, 32'h0404_0404};
    refill(32'h40, 0, 9, "s6b");
    step();
    chk("s6_end", {busy, mem_req, cache_we}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss handler between the instruction cache and IRAM. On a cache miss it fetches the whole block containing the missing PC from IRAM, one 32-bit word per beat, over a request/grant/response handshake. It assembles the words into the cache's block format and pulses the cache write enable for one cycle. The fetch unit stalls while busy=1 and holds miss_pc stable until the write completes.

Parameters:
PC_SIZE, 32, width of PC and IRAM byte address
BLOCK_SIZE, 128, cache block size in bits; multiple of 32, >=64; BEATS = BLOCK_SIZE/32
OFFSET_BITS, log2(BLOCK_SIZE/8), derived; byte offset bits within a block

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
miss_req  in  1  cache miss on current fetch (hit=0 with a valid fetch)
miss_pc  in  PC_SIZE  PC of the missing instruction
flush  in  1  abort the refill (redirect/mispredict)
busy  out  1  refill in progress; fetch stall
mem_req  out  1  IRAM read request
mem_addr  out  PC_SIZE  word-aligned IRAM byte address
mem_gnt  in  1  IRAM accepts the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word, little-endian (byte0 = bits 7:0)
cache_we  out  1  one-cycle write strobe to cache
cache_block  out  [0:BLOCK_SIZE-1]  assembled block, ascending-index vector

Behaviour:
- Reset (nrst=0 at posedge): state IDLE, beat=0, base=0, cache_block=0. busy, mem_req, cache_we = 0; mem_addr = 0. Applies mid-refill: the outstanding beat is abandoned and no cache write occurs.
- States: IDLE, REQ, WAIT, DRAIN, WRITE. Outputs are decoded from registered state only. busy=1 in every state except IDLE.
- IDLE: if miss_req=1 and flush=0: latch base = {miss_pc[PC_SIZE-1:OFFSET_BITS], zeros}, beat=0, go to REQ. Otherwise stay.
- REQ: mem_req=1, mem_addr = base + 4*beat.
  - flush=1 and mem_gnt=0: go to IDLE.
  - flush=1 and mem_gnt=1: go to DRAIN.
  - mem_gnt=1 (no flush): go to WAIT.
  - mem_req and mem_addr stay stable until granted.
- WAIT: mem_req=0, wait for mem_rvalid.
  - flush=1: go to DRAIN; if mem_rvalid=1 in that same cycle, go to IDLE instead, data discarded.
  - mem_rvalid=1 (no flush): store word into the slot for beat. If beat==BEATS-1 go to WRITE, else beat+1 and go to REQ.
- DRAIN: wait for mem_rvalid, discard the data, go to IDLE. No cache write. At most one IRAM transaction is ever outstanding.
- WRITE: cache_we=1 for exactly one cycle, then IDLE. flush is ignored here because the block is complete and valid. cache_block holds its value until the next refill overwrites it.
- Word packing: word i (address base+4i), byte k (mem_rdata[8k+7:8k]) goes to cache_block[32i+8k .. 32i+8k+7], MSB first. Bit by bit: cache_block[32i+8k+j] = mem_rdata[8k+7-j], for j=0..7.
- miss_req is ignored while busy. A miss_req in the IDLE cycle right after WRITE starts a new refill.
- Latency with a zero-wait IRAM (gnt same cycle as req, rvalid the next cycle): miss_req sampled in IDLE in cycle 0 gives cache_we=1 in cycle 1+2*BEATS (cycle 9 for BLOCK_SIZE=128). Each extra grant or response wait cycle adds one cycle.
- Address arithmetic is modulo 2^PC_SIZE. The base is block-aligned, so a burst never crosses a block boundary.

Test Plan:
1. Reset, then miss_pc=0x0000_1234 with a zero-wait IRAM returning 0x12345678, 0x00000013, 0xDEADBEEF, 0x0000006F -> mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; cache_we=1 only in cycle 9; cache_block[0:7]=0x78, [8:15]=0x56, [16:23]=0x34, [24:31]=0x12, [32:39]=0x13, [96:103]=0x6F.
2. IRAM withholds mem_gnt for 3 cycles on beat 1 and delays rvalid by 2 cycles on beat 2 -> mem_addr=0x1234 held while ungranted; cache_we in cycle 14; same block as scenario 1.
3. flush in WAIT of beat 2, rvalid 2 cycles later -> DRAIN, data discarded, IDLE; cache_we never asserted; busy drops the cycle after rvalid.
4. flush in REQ without grant -> IDLE next cycle, no further mem_req. flush during WRITE -> cache_we still 1 for that cycle.
5. nrst=0 during WAIT of beat 1 -> next cycle all outputs 0, state IDLE. A fresh miss_pc=0x0000_2008 then refills from 0x2000 correctly.
6. miss_req held high through a refill, then new miss_pc=0x0000_0040 in the cycle after WRITE -> no request during busy; the second refill starts at 0x40 with one idle cycle between the bursts.
